// File: rtl/pacman_pkg.sv
// Shared definitions for the Pac-Man / ghost grid-movement controllers:
// direction encoding, default maze size and step-controller state encoding.
package pacman_pkg;

    localparam int GRID_W_DEF = 32;
    localparam int GRID_H_DEF = 24;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'b00;
    localparam dir_t DIR_RIGHT = 2'b01;
    localparam dir_t DIR_DOWN  = 2'b10;
    localparam dir_t DIR_LEFT  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PROBE_NEW = 3'd1,
        ST_CHECK_NEW = 3'd2,
        ST_PROBE_CUR = 3'd3,
        ST_CHECK_CUR = 3'd4
    } step_state_e;

endpackage

// File: rtl/grid_neighbour.sv
// Combinational neighbour cell of (x, y) one step in dir, wrapping at the
// maze edges so the side tunnels connect.
module grid_neighbour
    import pacman_pkg::*;
#(
    parameter int GRID_W = GRID_W_DEF,
    parameter int GRID_H = GRID_H_DEF,
    parameter int XW     = 5,
    parameter int YW     = 5
) (
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  dir_t          dir,
    output logic [XW-1:0] nx,
    output logic [YW-1:0] ny
);

    // Compare against the edge before stepping so nothing leaves XW/YW bits.
    always_comb begin
        nx = x;
        ny = y;
        case (dir)
            DIR_UP:    ny = (y == YW'(0)) ? YW'(GRID_H - 1) : y - YW'(1);
            DIR_DOWN:  ny = (y == YW'(GRID_H - 1)) ? YW'(0) : y + YW'(1);
            DIR_LEFT:  nx = (x == XW'(0)) ? XW'(GRID_W - 1) : x - XW'(1);
            default:   nx = (x == XW'(GRID_W - 1)) ? XW'(0) : x + XW'(1);
        endcase
    end

endmodule

// File: rtl/pacman_step_ctrl.sv
// Pac-Man step controller: one grid step per rising edge of the game tick,
// trying the requested turn first and falling back to the current heading.
module pacman_step_ctrl
    import pacman_pkg::*;
#(
    parameter int GRID_W  = GRID_W_DEF,
    parameter int GRID_H  = GRID_H_DEF,
    parameter int XW      = 5,
    parameter int YW      = 5,
    parameter int START_X = 1,
    parameter int START_Y = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick_clk,
    input  logic          en,
    input  logic [1:0]    dir_req,
    input  logic          dir_req_valid,
    output logic [XW-1:0] maze_x,
    output logic [YW-1:0] maze_y,
    input  logic          maze_wall,
    output logic [XW-1:0] pos_x,
    output logic [YW-1:0] pos_y,
    output logic [1:0]    dir,
    output logic          moving,
    output logic          step_done
);

    step_state_e   state_q, state_d;
    logic          tick_d_q;
    logic          tick_edge;
    dir_t          dir_q, dir_d;
    dir_t          pending_q, pending_d;
    dir_t          try_dir_q, try_dir_d;
    logic [XW-1:0] pos_x_q, pos_x_d;
    logic [YW-1:0] pos_y_q, pos_y_d;
    logic          moving_q, moving_d;
    logic          step_done_q, step_done_d;
    dir_t          probe_dir;
    logic [XW-1:0] nb_x;
    logic [YW-1:0] nb_y;

    assign tick_edge = tick_clk & ~tick_d_q;

    // The neighbour in probe_dir is both the ROM address during PROBE_* and
    // the candidate position during CHECK_*; pos and dir are stable between.
    grid_neighbour #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .XW     (XW),
        .YW     (YW)
    ) u_nb (
        .x   (pos_x_q),
        .y   (pos_y_q),
        .dir (probe_dir),
        .nx  (nb_x),
        .ny  (nb_y)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (tick_edge && en) state_d = ST_PROBE_NEW;
            ST_PROBE_NEW: state_d = ST_CHECK_NEW;
            ST_CHECK_NEW: state_d = (!maze_wall || try_dir_q == dir_q) ? ST_IDLE : ST_PROBE_CUR;
            ST_PROBE_CUR: state_d = ST_CHECK_CUR;
            ST_CHECK_CUR: state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        probe_dir = try_dir_q;
        maze_x    = nb_x;
        maze_y    = nb_y;
        case (state_q)
            ST_PROBE_CUR, ST_CHECK_CUR: probe_dir = dir_q;
            ST_IDLE: begin
                maze_x = pos_x_q;
                maze_y = pos_y_q;
            end
            default: probe_dir = try_dir_q;
        endcase
    end

    always_comb begin
        dir_d       = dir_q;
        pending_d   = pending_q;
        try_dir_d   = try_dir_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        moving_d    = moving_q;
        step_done_d = 1'b0;

        if (dir_req_valid) pending_d = dir_req;

        case (state_q)
            ST_IDLE: begin
                // A request arriving on the edge cycle applies to this tick.
                if (tick_edge && en) try_dir_d = dir_req_valid ? dir_req : pending_q;
            end
            ST_CHECK_NEW: begin
                if (!maze_wall) begin
                    pos_x_d     = nb_x;
                    pos_y_d     = nb_y;
                    dir_d       = try_dir_q;
                    moving_d    = 1'b1;
                    step_done_d = 1'b1;
                end else if (try_dir_q == dir_q) begin
                    moving_d = 1'b0;
                end
            end
            ST_CHECK_CUR: begin
                if (!maze_wall) begin
                    pos_x_d     = nb_x;
                    pos_y_d     = nb_y;
                    moving_d    = 1'b1;
                    step_done_d = 1'b1;
                end else begin
                    moving_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_d_q    <= 1'b0;
            dir_q       <= DIR_RIGHT;
            pending_q   <= DIR_RIGHT;
            try_dir_q   <= DIR_RIGHT;
            pos_x_q     <= XW'(START_X);
            pos_y_q     <= YW'(START_Y);
            moving_q    <= 1'b0;
            step_done_q <= 1'b0;
        end else begin
            tick_d_q    <= tick_clk;
            dir_q       <= dir_d;
            pending_q   <= pending_d;
            try_dir_q   <= try_dir_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            moving_q    <= moving_d;
            step_done_q <= step_done_d;
        end
    end

    assign pos_x     = pos_x_q;
    assign pos_y     = pos_y_q;
    assign dir       = dir_q;
    assign moving    = moving_q;
    assign step_done = step_done_q;

endmodule

// File: tb/tb_pacman_step_ctrl.sv
// Scoreboard bench for pacman_step_ctrl: a grid-level model predicts each
// step; a monitor checks every step_done against the expected queue.
module tb_pacman_step_ctrl;

    localparam int GW = 32;
    localparam int GH = 24;
    localparam int XW = 5;
    localparam int YW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          tick_clk = 1'b0;
    logic          en = 1'b0;
    logic [1:0]    dir_req = 2'b00;
    logic          dir_req_valid = 1'b0;
    logic [XW-1:0] maze_x;
    logic [YW-1:0] maze_y;
    logic          maze_wall = 1'b0;
    logic [XW-1:0] pos_x;
    logic [YW-1:0] pos_y;
    logic [1:0]    dir;
    logic          moving;
    logic          step_done;

    pacman_step_ctrl #(
        .GRID_W  (GW),
        .GRID_H  (GH),
        .XW      (XW),
        .YW      (YW),
        .START_X (1),
        .START_Y (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tick_clk      (tick_clk),
        .en            (en),
        .dir_req       (dir_req),
        .dir_req_valid (dir_req_valid),
        .maze_x        (maze_x),
        .maze_y        (maze_y),
        .maze_wall     (maze_wall),
        .pos_x         (pos_x),
        .pos_y         (pos_y),
        .dir           (dir),
        .moving        (moving),
        .step_done     (step_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Registered wall ROM: data for the address seen at this edge appears next cycle.
    bit wall [GH][GW];
    always @(posedge clk) begin
        if (int'(maze_x) < GW && int'(maze_y) < GH) maze_wall <= wall[maze_y][maze_x];
        else maze_wall <= 1'b1;
    end

    typedef struct {
        int x;
        int y;
        int d;
        int at;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int mx = 1, my = 1, md = 1, mpend = 1, mmov = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic void nbr(input int x, input int y, input int d, output int nx, output int ny);
        int dx = 0, dy = 0;
        case (d)
            0: dy = -1;
            1: dx = 1;
            2: dy = 1;
            default: dx = -1;
        endcase
        nx = (x + dx + GW) % GW;
        ny = (y + dy + GH) % GH;
    endfunction

    always @(negedge clk) begin
        if (rst && step_done) begin
            if (exp_q.size() == 0) begin
                chk("step_done_unexpected", int'(step_done), 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("step_pos_x", int'(pos_x), e.x);
                chk("step_pos_y", int'(pos_y), e.y);
                chk("step_dir", int'(dir), e.d);
                chk("step_latency_cycle", cyc, e.at);
                chk("step_moving", int'(moving), 1);
            end
        end
    end

    task automatic model_reset();
        mx = 1; my = 1; md = 1; mpend = 1; mmov = 0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_pos_x"}, int'(pos_x), mx);
        chk({tag, "_pos_y"}, int'(pos_y), my);
        chk({tag, "_dir"}, int'(dir), md);
        chk({tag, "_moving"}, int'(moving), mmov);
    endtask

    task automatic strobe(input int r);
        @(posedge clk); #1;
        dir_req = 2'(r);
        dir_req_valid = 1'b1;
        mpend = r;
        @(posedge clk); #1;
        dir_req_valid = 1'b0;
    endtask

    // One tick with optional edge-cycle request, en drop after the edge,
    // a stray second edge mid-sequence, or a reset during CHECK_CUR.
    task automatic do_tick(input bit rv, input int r, input bit drop_en,
                           input bit extra_edge, input bit rst_mid);
        int e, tryd, nx, ny;
        bit run;
        @(posedge clk); #1;
        tick_clk = 1'b1;
        run = en;
        if (rv) begin
            dir_req = 2'(r);
            dir_req_valid = 1'b1;
        end
        e = cyc;
        tryd = rv ? r : mpend;
        if (rv) mpend = r;
        if (run) begin
            nbr(mx, my, tryd, nx, ny);
            if (!wall[ny][nx]) begin
                exp_q.push_back('{nx, ny, tryd, e + 3});
                mx = nx; my = ny; md = tryd; mmov = 1;
            end else if (tryd == md) begin
                mmov = 0;
            end else begin
                nbr(mx, my, md, nx, ny);
                if (!wall[ny][nx]) begin
                    if (!rst_mid) exp_q.push_back('{nx, ny, md, e + 5});
                    mx = nx; my = ny; mmov = 1;
                end else begin
                    mmov = 0;
                end
            end
        end
        if (rst_mid) model_reset();
        @(posedge clk); #1;
        dir_req_valid = 1'b0;
        if (extra_edge) tick_clk = 1'b0;
        if (drop_en) en = 1'b0;
        @(posedge clk); #1;
        tick_clk = extra_edge;
        @(posedge clk); #1;
        tick_clk = 1'b0;
        @(posedge clk); #1;
        if (rst_mid) rst = 1'b0;
        @(posedge clk); #1;
        if (rst_mid) begin
            chk("midrst_pos_x", int'(pos_x), 1);
            chk("midrst_pos_y", int'(pos_y), 1);
            chk("midrst_dir", int'(dir), 1);
            chk("midrst_moving", int'(moving), 0);
            chk("midrst_step_done", int'(step_done), 0);
            rst = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        if (drop_en) en = 1'b1;
        chk("step_arrived_in_time", exp_q.size(), 0);
        exp_q.delete();
        check_idle("idle");
    endtask

    task automatic open_maze();
        for (int y = 0; y < GH; y++)
            for (int x = 0; x < GW; x++)
                wall[y][x] = 1'b0;
    endtask

    initial begin
        int r, nx, ny;
        open_maze();
        en = 1'b1;
        rst = 1'b0;
        // Tick edges during reset must not move anything.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            tick_clk = ~tick_clk;
        end
        tick_clk = 1'b0;
        chk("rst_pos_x", int'(pos_x), 1);
        chk("rst_pos_y", int'(pos_y), 1);
        chk("rst_dir", int'(dir), 1);
        chk("rst_moving", int'(moving), 0);
        chk("rst_step_done", int'(step_done), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle("post_rst");

        repeat (3) do_tick(0, 0, 0, 0, 0);
        chk("open_run_x", int'(pos_x), 4);

        wall[2][4] = 1'b1;
        do_tick(1, 2, 0, 0, 0);
        chk("fallback_x", int'(pos_x), 5);
        chk("fallback_dir", int'(dir), 1);
        wall[2][4] = 1'b0;
        do_tick(0, 0, 0, 0, 0);
        chk("retry_turn_y", int'(pos_y), 2);
        chk("retry_turn_dir", int'(dir), 2);

        wall[3][5] = 1'b1;
        do_tick(0, 0, 0, 0, 0);
        chk("blocked_moving", int'(moving), 0);
        wall[3][5] = 1'b0;

        do_tick(1, 1, 0, 0, 0);
        repeat (26) do_tick(0, 0, 0, 0, 0);
        chk("wrap_right_x", int'(pos_x), 0);
        repeat (3) do_tick(1, 0, 0, 0, 0);
        chk("wrap_up_y", int'(pos_y), 23);

        do_tick(0, 0, 0, 1, 0);
        do_tick(1, 1, 1, 0, 0);
        en = 1'b0;
        do_tick(0, 0, 0, 0, 0);
        do_tick(1, 2, 0, 0, 0);
        en = 1'b1;

        r = (md + 1) % 4;
        nbr(mx, my, r, nx, ny);
        wall[ny][nx] = 1'b1;
        do_tick(1, r, 0, 0, 1);
        open_maze();

        for (int i = 0; i < 80; i++) begin
            if (i % 10 == 0) begin
                for (int y = 0; y < GH; y++)
                    for (int x = 0; x < GW; x++)
                        wall[y][x] = ($urandom_range(0, 3) == 0);
            end
            if ($urandom_range(0, 2) == 0) strobe(int'($urandom_range(0, 3)));
            do_tick(bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 0, 0, 0);
        end

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
